// File: rtl/fitness_scheduler.sv
// Streams a population through two fitness lanes, one even/odd pair per cycle.
// Writes every pair's fitness back and keeps the best member of the latest run.
module fitness_scheduler #(
  parameter  int POP_SIZE = 16,
  parameter  int FF_LAT   = 2,
  localparam int AW       = $clog2(POP_SIZE),
  localparam int PW       = (POP_SIZE / 2 > 1) ? $clog2(POP_SIZE / 2) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        pop_addr1,
  output logic [AW-1:0]        pop_addr2,
  input  logic signed [7:0]    pop_rdata1,
  input  logic signed [7:0]    pop_rdata2,
  output logic signed [7:0]    chrom1,
  output logic signed [7:0]    chrom2,
  input  logic signed [26:0]   fitness1,
  input  logic signed [26:0]   fitness2,
  output logic                 fit_we,
  output logic [PW-1:0]        fit_waddr,
  output logic signed [26:0]   fit_wdata1,
  output logic signed [26:0]   fit_wdata2,
  output logic                 best_valid,
  output logic [AW-1:0]        best_index,
  output logic signed [7:0]    best_chrom,
  output logic signed [26:0]   best_fitness
);

  localparam int DEPTH = FF_LAT + 2;
  localparam int SAMP  = FF_LAT + 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(POP_SIZE / 2 - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic                   issue;
  logic [PW-1:0]          pair_reg;
  logic [DEPTH-1:0]       vld_reg;
  logic [PW-1:0]          idx_reg [DEPTH];
  logic signed [7:0]      c1_reg  [1:DEPTH-1];
  logic signed [7:0]      c2_reg  [1:DEPTH-1];
  logic signed [7:0]      chrom1_reg, chrom2_reg;
  logic                   sample;
  logic                   lane2_wins;
  logic signed [26:0]     win_fit;
  logic signed [7:0]      win_chrom;
  logic [AW-1:0]          win_idx;
  logic                   best_valid_reg;
  logic [AW-1:0]          best_index_reg;
  logic signed [7:0]      best_chrom_reg;
  logic signed [26:0]     best_fitness_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  assign sample = vld_reg[SAMP];

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (pair_reg == LAST_PAIR) state_next = DRAIN;
      end
      DRAIN: begin
        if (sample && idx_reg[SAMP] == LAST_PAIR) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pair_reg <= '0;
    else if (issue) pair_reg <= (pair_reg == LAST_PAIR) ? '0 : pair_reg + 1'b1;
  end

  assign pop_addr1 = issue ? AW'({pair_reg, 1'b0}) : '0;
  assign pop_addr2 = issue ? AW'({pair_reg, 1'b1}) : '0;

  // Stage k is valid k+1 cycles after issue; chromosome copies ride along from stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
      for (int i = 0; i < DEPTH; i++) idx_reg[i] <= '0;
      for (int i = 1; i < DEPTH; i++) begin
        c1_reg[i] <= '0;
        c2_reg[i] <= '0;
      end
    end else begin
      vld_reg    <= {vld_reg[DEPTH-2:0], issue};
      idx_reg[0] <= pair_reg;
      for (int i = 1; i < DEPTH; i++) idx_reg[i] <= idx_reg[i-1];
      c1_reg[1] <= pop_rdata1;
      c2_reg[1] <= pop_rdata2;
      for (int i = 2; i < DEPTH; i++) begin
        c1_reg[i] <= c1_reg[i-1];
        c2_reg[i] <= c2_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chrom1_reg <= '0;
      chrom2_reg <= '0;
    end else if (vld_reg[0]) begin
      chrom1_reg <= pop_rdata1;
      chrom2_reg <= pop_rdata2;
    end
  end

  assign chrom1     = chrom1_reg;
  assign chrom2     = chrom2_reg;
  assign fit_we     = sample;
  assign fit_waddr  = idx_reg[SAMP];
  assign fit_wdata1 = sample ? fitness1 : '0;
  assign fit_wdata2 = sample ? fitness2 : '0;

  // Lane 1 holds the lower index, so it keeps an equal compare.
  assign lane2_wins = fitness2 > fitness1;
  assign win_fit    = lane2_wins ? fitness2 : fitness1;
  assign win_chrom  = lane2_wins ? c2_reg[SAMP] : c1_reg[SAMP];
  assign win_idx    = AW'({idx_reg[SAMP], lane2_wins});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_valid_reg   <= 1'b0;
      best_index_reg   <= '0;
      best_chrom_reg   <= '0;
      best_fitness_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      best_valid_reg <= 1'b0;
    end else if (sample && (!best_valid_reg || win_fit > best_fitness_reg)) begin
      best_valid_reg   <= 1'b1;
      best_index_reg   <= win_idx;
      best_chrom_reg   <= win_chrom;
      best_fitness_reg <= win_fit;
    end
  end

  assign best_valid   = best_valid_reg;
  assign best_index   = best_index_reg;
  assign best_chrom   = best_chrom_reg;
  assign best_fitness = best_fitness_reg;

endmodule

// File: tb/tb_fitness_scheduler.sv
// Directed bench for fitness_scheduler with a 4-member population, a registered
// population memory and a two-cycle square (or negated square) fitness model.
module tb_fitness_scheduler;

  localparam int POP_SIZE = 4;
  localparam int FF_LAT   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               busy, done;
  logic [1:0]         pop_addr1, pop_addr2;
  logic signed [7:0]  pop_rdata1, pop_rdata2;
  logic signed [7:0]  chrom1, chrom2;
  logic signed [26:0] fitness1, fitness2;
  logic               fit_we;
  logic [0:0]         fit_waddr;
  logic signed [26:0] fit_wdata1, fit_wdata2;
  logic               best_valid;
  logic [1:0]         best_index;
  logic signed [7:0]  best_chrom;
  logic signed [26:0] best_fitness;

  logic signed [7:0]  mem [4];
  logic               neg = 1'b0;
  logic signed [26:0] f1_d, f2_d;
  int checks = 0;
  int failures = 0;

  fitness_scheduler #(.POP_SIZE(POP_SIZE), .FF_LAT(FF_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pop_addr1(pop_addr1), .pop_addr2(pop_addr2),
    .pop_rdata1(pop_rdata1), .pop_rdata2(pop_rdata2),
    .chrom1(chrom1), .chrom2(chrom2),
    .fitness1(fitness1), .fitness2(fitness2),
    .fit_we(fit_we), .fit_waddr(fit_waddr),
    .fit_wdata1(fit_wdata1), .fit_wdata2(fit_wdata2),
    .best_valid(best_valid), .best_index(best_index),
    .best_chrom(best_chrom), .best_fitness(best_fitness)
  );

  always #5 clk = ~clk;

  function automatic logic signed [26:0] fmodel(input logic signed [7:0] c, input logic n);
    logic signed [26:0] x;
    x = c;
    return n ? -(x * x) : x * x;
  endfunction

  always @(posedge clk) begin
    pop_rdata1 <= mem[pop_addr1];
    pop_rdata2 <= mem[pop_addr2];
    f1_d       <= fmodel(chrom1, neg);
    f2_d       <= fmodel(chrom2, neg);
    fitness1   <= f1_d;
    fitness2   <= f2_d;
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run(input string name,
                     input logic signed [7:0] p0, input logic signed [7:0] p1,
                     input logic signed [7:0] p2, input logic signed [7:0] p3,
                     input logic ng, input logic hold_start,
                     input int w00, input int w01, input int w10, input int w11,
                     input int bi, input int bc, input int bf);
    int nw, ndone, dcyc, first_w, gaps;
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
    neg   = ng;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    chk({name, "_bvalid_clr"}, best_valid, 0);
    nw = 0; ndone = 0; dcyc = -1; first_w = -1; gaps = 0;
    for (int cyc = 0; cyc < 20 && ndone == 0; cyc++) begin
      if (!busy) gaps++;
      if (fit_we) begin
        if (first_w < 0) first_w = cyc;
        $display("%s cyc=%0d write pair=%0d w1=%0d w2=%0d", name, cyc, fit_waddr, fit_wdata1, fit_wdata2);
        if (nw == 0) begin
          chk({name, "_w0_addr"}, fit_waddr, 0);
          chk({name, "_w0_d1"}, fit_wdata1, w00);
          chk({name, "_w0_d2"}, fit_wdata2, w01);
        end else begin
          chk({name, "_w1_addr"}, fit_waddr, 1);
          chk({name, "_w1_d1"}, fit_wdata1, w10);
          chk({name, "_w1_d2"}, fit_wdata2, w11);
        end
        nw++;
      end
      if (done) begin
        ndone++;
        dcyc  = cyc;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({name, "_done_seen"}, ndone, 1);
    chk({name, "_done_latency"}, dcyc + 1, 7);
    chk({name, "_first_write_cyc"}, first_w, 4);
    chk({name, "_writes"}, nw, 2);
    chk({name, "_busy_gaps"}, gaps, 0);
    chk({name, "_best_valid"}, best_valid, 1);
    chk({name, "_best_index"}, best_index, bi);
    chk({name, "_best_chrom"}, best_chrom, bc);
    chk({name, "_best_fitness"}, best_fitness, bf);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_we"}, fit_we, 0);
    chk({name, "_best_hold"}, best_fitness, bf);
  endtask

  initial begin
    mem[0] = 0; mem[1] = 0; mem[2] = 0; mem[3] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_chrom1", chrom1, 0);
    chk("rst_best_valid", best_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_we", fit_we, 0);

    run("basic", 3, -5, 1, 2, 1'b0, 1'b0, 9, 25, 1, 4, 1, -5, 25);
    run("b2b", -2, 0, -3, 1, 1'b0, 1'b0, 4, 0, 9, 1, 2, -3, 9);
    run("neg", 1, 2, 3, 4, 1'b1, 1'b0, -1, -4, -9, -16, 0, 1, -1);
    run("tie", 4, -4, 4, -4, 1'b0, 1'b0, 16, 16, 16, 16, 0, 4, 16);
    run("hold", 7, -1, 0, 6, 1'b0, 1'b1, 49, 1, 0, 36, 0, 7, 49);

    // Abort a run at its fourth cycle.
    mem[0] = 3; mem[1] = -5; mem[2] = 1; mem[3] = 2;
    neg   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_we", fit_we, 0);
    chk("mid_rst_addr1", pop_addr1, 0);
    chk("mid_rst_addr2", pop_addr2, 0);
    chk("mid_rst_chrom1", chrom1, 0);
    chk("mid_rst_chrom2", chrom2, 0);
    chk("mid_rst_waddr", fit_waddr, 0);
    chk("mid_rst_wdata1", fit_wdata1, 0);
    chk("mid_rst_bvalid", best_valid, 0);
    chk("mid_rst_bindex", best_index, 0);
    chk("mid_rst_bchrom", best_chrom, 0);
    chk("mid_rst_bfit", best_fitness, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_quiet", done | fit_we | busy, 0);
      @(posedge clk); #1;
    end
    run("after_rst", 3, -5, 1, 2, 1'b0, 1'b0, 9, 25, 1, 4, 1, -5, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fitness_scheduler.md
FITNESS_SCHEDULER -- requirements
Module: fitness_scheduler

Interface
REQ-001 The block SHALL have parameter POP_SIZE, default 16, population size; even, >= 2.
REQ-002 The block SHALL have parameter FF_LAT, default 2, cycles from chrom1/chrom2 presented to fitness1/fitness2 valid.
REQ-003 AW SHALL equal $clog2(POP_SIZE), and PW SHALL equal $clog2(POP_SIZE/2), minimum 1.
REQ-004 Port clk  input  1  single clock, rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port start  input  1  one-cycle request to evaluate the whole population.
REQ-007 Port busy  output  1  run in progress.
REQ-008 Port done  output  1  one-cycle pulse when a run completes.
REQ-009 Port pop_addr1 / pop_addr2  output  AW each  population read addresses (even / odd index).
REQ-010 Port pop_rdata1 / pop_rdata2  input  8 signed each  population data, valid one cycle after address.
REQ-011 Port chrom1 / chrom2  output  8 signed each  operands to the two fitness lanes.
REQ-012 Port fitness1 / fitness2  input  27 signed each  lane results.
REQ-013 Port fit_we  output  1  fitness write-back strobe.
REQ-014 Port fit_waddr  output  PW  pair index of the write.
REQ-015 Port fit_wdata1 / fit_wdata2  output  27 signed each  fitness of the even / odd member.
REQ-016 Port best_valid, best_index (AW), best_chrom (8 signed), best_fitness (27 signed)  output  best of the latest run.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-018 IDLE->ISSUE SHALL occur on start=1, which also clears best_valid; start SHALL be ignored in all other states.
REQ-019 In ISSUE, pair p=0..POP_SIZE/2-1 SHALL be issued one per cycle with pop_addr1=2p and pop_addr2=2p+1; after the last pair, ISSUE->DRAIN.
REQ-020 pop_rdata of pair p SHALL be registered onto chrom1/chrom2 the cycle after it is valid, so chrom is valid at issue+2.
REQ-021 fitness1/fitness2 of pair p SHALL be sampled at issue+2+FF_LAT, tracked by a valid/pair-index shift register, with no stalls.
REQ-022 On each sample cycle: fit_we=1, fit_waddr=p, fit_wdata1=fitness1, fit_wdata2=fitness2, all combinational from the sampled inputs.
REQ-023 Best update: a candidate SHALL replace best when best_valid=0 or candidate > best_fitness (signed, strict); ties SHALL keep the lower index; within a pair, lane1 SHALL win an equal compare; the update is registered.
REQ-024 DRAIN->DONE SHALL occur on the cycle after the last write-back; DONE SHALL assert done for one cycle, then go to IDLE.
REQ-025 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-026 A run SHALL last POP_SIZE/2 + FF_LAT + 3 cycles from the start edge to the done pulse.
REQ-027 Outside sample cycles fit_we SHALL be 0; chrom1/chrom2 SHALL hold their last value when idle.
REQ-028 best_* SHALL hold after done until the next start.

Reset
REQ-029 While rst_n=0, asynchronously: state=IDLE, busy=0, done=0, fit_we=0, pop_addr*=0, chrom*=0, fit_waddr=0, best_valid=0, best_index=0, best_chrom=0, best_fitness=0, shift register cleared.
REQ-030 Reset mid-run SHALL abandon the run with no done pulse and no further writes; the first start after release SHALL begin a fresh run.

Verification
REQ-031 POP_SIZE=4, FF_LAT=2, model fitness=chrom*chrom: pop {3,-5,1,2}, start -> writes (0:9,25), (1:1,4); done at cycle 7 after start; best_index=1, best_chrom=-5, best_fitness=25.
REQ-032 Tie case: pop {4,-4,4,-4} -> best_index=0, best_chrom=4, best_fitness=16.
REQ-033 All negative case, model fitness=-chrom*chrom: pop {1,2,3,4} -> best_index=0, best_fitness=-1, best_valid=1.
REQ-034 Pulse start every cycle during a run -> exactly one done pulse and 2 writes; busy continuous.
REQ-035 Deassert rst_n at cycle 3 of a run -> all outputs zero immediately; then start -> a complete correct run.
REQ-036 Back-to-back: start the cycle after done -> best_valid=0 at the next cycle, then new results, with no stale best carried over.
